// File: rtl/alu_iter.sv
// alu_iter: sequential integer ALU with registered result and valid/ready handshakes.
// Non-shift ops finish in one cycle; shifts iterate SHIFT_STEP bits per cycle to keep
// the shifter small.
// Optional feature: define ALU_ROTATE_EN to enable ROL/ROR on the iterative shift path.
// Without it, ROL/ROR codes fall through to the a_i pass-through.

// Op encoding shared with defs.sv; the guards let a previously included defs.sv win.
`ifndef ALU_NONE
`define ALU_NONE 4'd0
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'd1
`endif
`ifndef ALU_SUB
`define ALU_SUB  4'd2
`endif
`ifndef ALU_AND
`define ALU_AND  4'd3
`endif
`ifndef ALU_OR
`define ALU_OR   4'd4
`endif
`ifndef ALU_XOR
`define ALU_XOR  4'd5
`endif
`ifndef ALU_SLT
`define ALU_SLT  4'd6
`endif
`ifndef ALU_SLTU
`define ALU_SLTU 4'd7
`endif
`ifndef ALU_SLL
`define ALU_SLL  4'd8
`endif
`ifndef ALU_SRL
`define ALU_SRL  4'd9
`endif
`ifndef ALU_SRA
`define ALU_SRA  4'd10
`endif
`ifndef ALU_ROL
`define ALU_ROL  4'd11
`endif
`ifndef ALU_ROR
`define ALU_ROR  4'd12
`endif

module alu_iter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);
    // One extra bit so SHIFT_STEP == XLEN still fits for the step comparison.
    localparam logic [SHW:0] StepMax = (SHW + 1)'(SHIFT_STEP);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   work_q, work_d;
    logic [SHW-1:0]    remaining_q, remaining_d;
    logic              fill_q, fill_d;
    logic              left_q, left_d;
    logic [XLEN-1:0]   out_q, out_d;
`ifdef ALU_ROTATE_EN
    logic              rotate_q, rotate_d;
`endif

    logic              accept;
    logic [SHW-1:0]    shamt;
    logic              is_shift_op;
    logic              launch_left;
    logic              launch_rotate;
    logic [XLEN-1:0]   imm_result;
    logic [SHW-1:0]    step;
    logic [XLEN-1:0]   hi_fill;
    logic [XLEN-1:0]   lo_fill;
    logic [2*XLEN-1:0] right_ext;
    logic [2*XLEN-1:0] left_ext;
    logic [XLEN-1:0]   shifted;

    assign shamt     = b_i[SHW-1:0];
    assign out       = out_q;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    // A result slot frees up either from idle or as the held result is consumed.
    assign in_ready  = rst_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
    assign accept    = in_valid & in_ready;

    // Decode which ops take the iterative path and in which direction.
    always_comb begin
        is_shift_op   = 1'b0;
        launch_left   = 1'b0;
        launch_rotate = 1'b0;
        case (op)
            `ALU_SLL: begin
                is_shift_op = 1'b1;
                launch_left = 1'b1;
            end
            `ALU_SRL, `ALU_SRA: is_shift_op = 1'b1;
`ifdef ALU_ROTATE_EN
            `ALU_ROL: begin
                is_shift_op   = 1'b1;
                launch_left   = 1'b1;
                launch_rotate = 1'b1;
            end
            `ALU_ROR: begin
                is_shift_op   = 1'b1;
                launch_rotate = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Single-cycle results; shifts by zero and unknown codes pass a_i through.
    always_comb begin
        imm_result = a_i;
        case (op)
            `ALU_ADD:  imm_result = a_i + b_i;
            `ALU_SUB:  imm_result = a_i - b_i;
            `ALU_AND:  imm_result = a_i & b_i;
            `ALU_OR:   imm_result = a_i | b_i;
            `ALU_XOR:  imm_result = a_i ^ b_i;
            `ALU_SLT:  imm_result = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            `ALU_SLTU: imm_result = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            default:   imm_result = a_i;
        endcase
    end

    // One iteration of the shifter: move by min(SHIFT_STEP, remaining).
    always_comb begin
        step = ({1'b0, remaining_q} >= StepMax) ? StepMax[SHW-1:0] : remaining_q;
`ifdef ALU_ROTATE_EN
        hi_fill = rotate_q ? work_q : {XLEN{fill_q}};
        lo_fill = rotate_q ? work_q : '0;
`else
        hi_fill = {XLEN{fill_q}};
        lo_fill = '0;
`endif
        // Double-width shifts let the fill (or the wrapped bits) enter at the open end.
        right_ext = {hi_fill, work_q} >> step;
        left_ext  = {work_q, lo_fill} << step;
        shifted   = left_q ? left_ext[2*XLEN-1:XLEN] : right_ext[XLEN-1:0];
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;
        left_d      = left_q;
        out_d       = out_q;
`ifdef ALU_ROTATE_EN
        rotate_d    = rotate_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    if (is_shift_op && (shamt != '0)) begin
                        state_d     = StShift;
                        work_d      = a_i;
                        remaining_d = shamt;
                        fill_d      = (op == `ALU_SRA) & a_i[XLEN-1];
                        left_d      = launch_left;
`ifdef ALU_ROTATE_EN
                        rotate_d    = launch_rotate;
`endif
                    end else begin
                        out_d   = imm_result;
                        state_d = StDone;
                    end
                end
            end
            StShift: begin
                work_d      = shifted;
                remaining_d = remaining_q - step;
                if (remaining_q == step) begin
                    out_d   = shifted;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifndef ALU_ROTATE_EN
    // Rotate decode is only consumed when the feature is built in.
    logic unused_rotate;
    assign unused_rotate = launch_rotate;
`endif

    // State and datapath registers; reset aborts any shift in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            work_q      <= '0;
            remaining_q <= '0;
            fill_q      <= 1'b0;
            left_q      <= 1'b0;
            out_q       <= '0;
`ifdef ALU_ROTATE_EN
            rotate_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
            left_q      <= left_d;
            out_q       <= out_d;
`ifdef ALU_ROTATE_EN
            rotate_q    <= rotate_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed checks of alu_iter at SHIFT_STEP = 1, 2 and 4 (XLEN = 32).
// Index 0 -> step 1, index 1 -> step 2, index 2 -> step 4. Each instance has its own
// handshake signals; clock and reset are shared.

module tb_alu_iter;

    localparam logic [3:0] OpNone = 4'd0;
    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpAnd  = 4'd3;
    localparam logic [3:0] OpOr   = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpSlt  = 4'd6;
    localparam logic [3:0] OpSltu = 4'd7;
    localparam logic [3:0] OpSll  = 4'd8;
    localparam logic [3:0] OpSrl  = 4'd9;
    localparam logic [3:0] OpSra  = 4'd10;
    localparam logic [3:0] OpRol  = 4'd11;
    localparam logic [3:0] OpRor  = 4'd12;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [3:0]  op_s      [3];
    logic [31:0] a_s       [3];
    logic [31:0] b_s       [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] dout      [3];
    logic        busy      [3];

    int errors = 0;
    int checks = 0;

    alu_iter #(.XLEN(32), .SHIFT_STEP(1)) u_step1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .op(op_s[0]),
        .a_i(a_s[0]), .b_i(b_s[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(dout[0]), .busy(busy[0])
    );

    alu_iter #(.XLEN(32), .SHIFT_STEP(2)) u_step2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .op(op_s[1]),
        .a_i(a_s[1]), .b_i(b_s[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(dout[1]), .busy(busy[1])
    );

    alu_iter #(.XLEN(32), .SHIFT_STEP(4)) u_step4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .op(op_s[2]),
        .a_i(a_s[2]), .b_i(b_s[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out(dout[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, count edges until out_valid (accept edge counts as 1).
    task automatic run_op(input int k, input string tag, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        int low;
        @(negedge clk);
        in_valid[k]  = 1'b1;
        op_s[k]      = o;
        a_s[k]       = a;
        b_s[k]       = b;
        out_ready[k] = 1'b1;
        check({tag, "_in_ready"}, {31'd0, in_ready[k]}, 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs to confirm they were captured at the accept edge.
        in_valid[k] = 1'b0;
        op_s[k]     = OpSub;
        a_s[k]      = 32'hDEAD_BEEF;
        b_s[k]      = 32'h1234_5678;
        lat = 1;
        low = 0;
        while (!out_valid[k] && lat < 200) begin
            if (!in_ready[k]) low++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_out"}, dout[k], exp);
        check({tag, "_busy_cycles"}, 32'(low), 32'(exp_lat - 1));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            op_s[k]      = OpNone;
            a_s[k]       = '0;
            b_s[k]       = '0;
            out_ready[k] = 1'b1;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out",       dout[2],                 32'd0);
        check("rst_out_valid", {31'd0, out_valid[2]},   32'd0);
        check("rst_busy",      {31'd0, busy[2]},        32'd0);
        check("rst_in_ready",  {31'd0, in_ready[2]},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", {31'd0, in_ready[2]},    32'd1);

        // Single-cycle ops on the step-4 instance.
        run_op(2, "add_wrap", OpAdd,  32'hFFFF_FFFF, 32'd1,        32'd0,          1);
        run_op(2, "sub_wrap", OpSub,  32'd0,         32'd1,        32'hFFFF_FFFF,  1);
        run_op(2, "slt",      OpSlt,  32'h8000_0000, 32'd1,        32'd1,          1);
        run_op(2, "sltu",     OpSltu, 32'h8000_0000, 32'd1,        32'd0,          1);
        run_op(2, "and",      OpAnd,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
        run_op(2, "or",       OpOr,   32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1);
        run_op(2, "none",     OpNone, 32'hCAFE_0001, 32'h5555_5555, 32'hCAFE_0001, 1);
        run_op(2, "undef",    4'd15,  32'h0BAD_F00D, 32'h1,        32'h0BAD_F00D,  1);
        // Iterative shifts at step 4: shamt 9 -> 3 shift cycles; 0x20 masks to shamt 0.
        run_op(2, "sll9",     OpSll,  32'h1,         32'h29,       32'h200,        4);
        run_op(2, "sll0",     OpSll,  32'h1,         32'h20,       32'h1,          1);
        run_op(2, "srl4",     OpSrl,  32'hF000_0000, 32'd4,        32'h0F00_0000,  2);

        // Step-1 boundary shifts.
        run_op(0, "sra31",    OpSra,  32'h8000_0000, 32'd31,       32'hFFFF_FFFF, 32);
        run_op(0, "srl31",    OpSrl,  32'h8000_0000, 32'd31,       32'h1,         32);

        // Rotates on the step-2 instance.
`ifdef ALU_ROTATE_EN
        run_op(1, "ror1",     OpRor,  32'h1,         32'd1,        32'h8000_0000,  2);
        run_op(1, "rol4",     OpRol,  32'h8000_0001, 32'd4,        32'h0000_0018,  3);
`else
        run_op(1, "ror1",     OpRor,  32'h1,         32'd1,        32'h1,          1);
        run_op(1, "rol4",     OpRol,  32'h8000_0001, 32'd4,        32'h8000_0001,  1);
`endif
        run_op(1, "sra_step2", OpSra, 32'h8000_0010, 32'd3,        32'hF000_0002,  3);

        // Backpressure: hold the result, then back-to-back accept on release.
        @(negedge clk);
        in_valid[2]  = 1'b1;
        op_s[2]      = OpAdd;
        a_s[2]       = 32'd2;
        b_s[2]       = 32'd3;
        out_ready[2] = 1'b0;
        @(posedge clk);
        #1;
        op_s[2] = OpXor;
        a_s[2]  = 32'hF0;
        b_s[2]  = 32'h0F;
        check("bp_first_out", dout[2], 32'd5);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_out",      dout[2],               32'd5);
            check("bp_hold_valid",    {31'd0, out_valid[2]}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready[2]},  32'd0);
        end
        @(negedge clk);
        out_ready[2] = 1'b1;
        #1;
        check("bp_release_in_ready", {31'd0, in_ready[2]}, 32'd1);
        @(posedge clk);
        #1;
        in_valid[2] = 1'b0;
        check("bp_b2b_out",   dout[2],               32'hFF);
        check("bp_b2b_valid", {31'd0, out_valid[2]}, 32'd1);
        @(posedge clk);
        #1;
        check("bp_drain_valid", {31'd0, out_valid[2]}, 32'd0);

        // Reset in the middle of a 20-cycle shift on the step-1 instance.
        @(negedge clk);
        in_valid[0] = 1'b1;
        op_s[0]     = OpSrl;
        a_s[0]      = 32'hFFFF_FFFF;
        b_s[0]      = 32'd20;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy_pre", {31'd0, busy[0]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    {31'd0, out_valid[0]}, 32'd0);
        check("mid_rst_out",      dout[0],               32'd0);
        check("mid_rst_busy",     {31'd0, busy[0]},      32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready[0]},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, "post_rst_add", OpAdd, 32'd2, 32'd3, 32'd5, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
